wb_daq_multi_channel: RTL and testbench
=======================================

Name: wb_daq_multi_channel

Overview:
Multi-channel data-acquisition front end running entirely on the Wishbone clock.
- Accepts per-channel ADC samples with valid strobes and packs each channel's samples into dw-bit words.
- Arbitrates round-robin among channels into one shared channel-tagged FIFO.
- Presents FIFO output on a valid/ready stream for the SRAM writer.
- Adds over the single-channel design: channel count, pack mode, FIFO depth, per-channel overflow detection.

Parameters:
dw, 32, packed output word width; must be an integer multiple of adc_dw
adc_dw, 8, ADC sample width
num_channels, 4, number of ADC channels (2..16)
cw, 2, channel tag width; 2**cw >= num_channels
fifo_aw, 4, FIFO address width; depth = 2**fifo_aw

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  reset
enable  in  num_channels  per-channel acquisition enable
pack_mode  in  1  1 = pack dw/adc_dw samples per word; 0 = one sample per word, zero-extended
adc_valid  in  num_channels  per-channel sample strobe
adc_data  in  num_channels*adc_dw  channel i sample at [i*adc_dw +: adc_dw]
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  dw  packed word at FIFO head
out_channel  out  cw  channel tag of head word
fifo_count  out  fifo_aw+1  words held in FIFO
overflow  out  num_channels  sticky per-channel word-drop flag
clear_overflow  in  1  clears all overflow bits

Behaviour:
- Reset: one clock (wb_clk); reset (wb_rst) is synchronous and active-high.
- While wb_rst is high, all packer counts, pending flags, FIFO pointers, overflow bits and the round-robin pointer are cleared at the clock edge.
- Reset state: out_valid=0, out_data=0, out_channel=0, fifo_count=0, overflow=0. Reset mid-operation discards all data.

Packer (per channel i):
- A sample is accepted only when adc_valid[i] & enable[i].
- pack_mode=1: sample k (k=0..R-1, R=dw/adc_dw) goes to bits [k*adc_dw +: adc_dw]; sample 0 lands in the LSBs. After the R-th sample, the word is complete and the count returns to 0.
- pack_mode=0: every accepted sample completes a word, zero-extended.
- Deasserting enable[i] zeroes that packer's count and discards the partial word. A completed pending word is kept.
- Any change of pack_mode (detected against a registered copy) zeroes all packer counts on the next edge; partial words are discarded.

Pending stage (per channel):
- A completed word is loaded into that channel's pending register, and pending[i] is set on the edge that accepts the final sample.
- If pending[i] is already set and is not being granted that cycle, the new word is dropped and overflow[i] is set.
- If a grant and a new completion occur in the same cycle, the new word replaces the granted one, pending stays 1, and there is no overflow.
- overflow bits are cleared by clear_overflow. If a set and a clear occur in the same cycle, set wins.

Arbiter:
- Each cycle with fifo_count < 2**fifo_aw and any pending[i] set, grant exactly one channel.
- Search order is round-robin starting at last_grant+1 and wrapping at num_channels.
- The granted {channel, word} is written into the FIFO and pending is cleared; last_grant updates.
- When full, no grant is made. Pending words wait, and further completions on those channels overflow.

FIFO:
- Show-ahead: out_valid = (fifo_count != 0), and out_data/out_channel reflect the head combinationally from registered storage.
- Pop on out_valid & out_ready.
- Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo depth.
- A pop while full does not enable a push in the same cycle, because the grant uses the pre-pop count.

Latency: final sample accepted at edge t → pending at t → FIFO write at edge t+1 → out_valid high after edge t+1, with no contention.

Test Plan:
- Single channel, pack_mode=1, dw=32/adc_dw=8: ch0 samples 0x11,0x22,0x33,0x44 on consecutive cycles → exactly one word 0x44332211, out_channel=0, out_valid 2 edges after the 4th sample.
- pack_mode=0: ch2 sample 0xA5 → out_data=0x000000A5, out_channel=2; fifo_count=1 until out_ready pops it.
- All 4 channels complete words in the same cycle, with out_ready=1 → FIFO order ch0,ch1,ch2,ch3. A second simultaneous burst, after last_grant=3, is also ordered ch0..ch3; with last_grant=1 it is ordered ch2,ch3,ch0,ch1.
- out_ready=0, ch0 streaming in pack_mode=0 → fifo_count saturates at 16, pending[0] holds word 17, and word 18 sets overflow[0]=1. clear_overflow pulse → overflow=0. With out_ready=1, words 1..17 drain in order.
- Deassert enable[1] after 2 of 4 samples, then re-enable and send 4 samples → only one word, containing the last 4 samples. A pack_mode toggle mid-word likewise discards the partial word.
- Assert wb_rst for one cycle with FIFO holding 5 words and pending set → next cycle out_valid=0, fifo_count=0, overflow=0, and no stale word ever appears.

Source files
------------

// File: rtl/wb_daq_multi_channel.sv
// -----------------------------------------------------------------------------
// wb_daq_multi_channel
// Multi-channel ADC acquisition front end on the Wishbone clock. Each channel
// packs its samples into dw-bit words and holds one completed word in a pending
// register. A round-robin arbiter moves pending words into a shared
// channel-tagged show-ahead FIFO, which drains over a valid/ready stream.
//
// Ports
//   wb_clk, wb_rst   clock, synchronous active-high reset
//   enable           per-channel acquisition enable
//   pack_mode        1 = dw/adc_dw samples per word, 0 = one zero-extended sample
//   adc_valid        per-channel sample strobe
//   adc_data         channel i sample at [i*adc_dw +: adc_dw]
//   out_valid        FIFO head valid
//   out_ready        consumer accepts head
//   out_data         word at FIFO head
//   out_channel      channel tag of head word
//   fifo_count       words held in FIFO
//   overflow         sticky per-channel word-drop flags
//   clear_overflow   clears all overflow flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module wb_daq_multi_channel #(
    parameter int unsigned dw           = 32,
    parameter int unsigned adc_dw       = 8,
    parameter int unsigned num_channels = 4,
    parameter int unsigned cw           = 2,
    parameter int unsigned fifo_aw      = 4
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst,
    input  logic [num_channels-1:0]        enable,
    input  logic                           pack_mode,
    input  logic [num_channels-1:0]        adc_valid,
    input  logic [num_channels*adc_dw-1:0] adc_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [dw-1:0]                  out_data,
    output logic [cw-1:0]                  out_channel,
    output logic [fifo_aw:0]               fifo_count,
    output logic [num_channels-1:0]        overflow,
    input  logic                           clear_overflow
);

    localparam int unsigned R     = dw / adc_dw;
    localparam int unsigned RW    = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned DEPTH = 1 << fifo_aw;
    localparam logic [fifo_aw:0] FULL_CNT = (fifo_aw+1)'(DEPTH);
    localparam logic [RW-1:0]    LAST_CNT = RW'(R - 1);

    // Registered state
    logic                    r_pack_q;
    logic [RW-1:0]           r_cnt       [num_channels];
    logic [dw-1:0]           r_part      [num_channels];
    logic [dw-1:0]           r_pend_word [num_channels];
    logic [num_channels-1:0] r_pend;
    logic [num_channels-1:0] r_ovf;
    logic [cw-1:0]           r_rr_start;
    logic [dw-1:0]           r_mem_data  [DEPTH];
    logic [cw-1:0]           r_mem_ch    [DEPTH];
    logic [fifo_aw-1:0]      r_wr_ptr;
    logic [fifo_aw-1:0]      r_rd_ptr;
    logic [fifo_aw:0]        r_count;

    // Combinational signals
    logic                    w_mode_chg;
    logic [adc_dw-1:0]       w_sample    [num_channels];
    logic [dw-1:0]           w_part_next [num_channels];
    logic [dw-1:0]           w_cmp_word  [num_channels];
    logic [num_channels-1:0] w_acc;
    logic [num_channels-1:0] w_cmp;
    logic                    w_gnt_vld;
    logic [cw-1:0]           w_gnt_idx;
    logic [num_channels-1:0] w_gnt_onehot;
    logic                    w_push;
    logic                    w_pop;

    assign w_mode_chg = (pack_mode != r_pack_q);

    // Per-channel packer: accept, merge sample into partial word, detect completion
    always_comb begin
        for (int i = 0; i < num_channels; i++) begin
            w_sample[i]    = adc_data[i*adc_dw +: adc_dw];
            // A mode-change cycle only flushes partial words; its sample is ignored.
            w_acc[i]       = adc_valid[i] & enable[i] & ~w_mode_chg;
            w_part_next[i] = r_part[i];
            w_part_next[i][int'(r_cnt[i])*adc_dw +: adc_dw] = w_sample[i];
            w_cmp[i]       = w_acc[i] & (~pack_mode | (r_cnt[i] == LAST_CNT));
            w_cmp_word[i]  = pack_mode ? w_part_next[i] : dw'(w_sample[i]);
        end
    end

    // Round-robin grant starting at the channel after the last one served
    always_comb begin
        int idx;
        idx          = 0;
        w_gnt_vld    = 1'b0;
        w_gnt_idx    = '0;
        w_gnt_onehot = '0;
        if (r_count < FULL_CNT) begin
            for (int j = 0; j < num_channels; j++) begin
                idx = (int'(r_rr_start) + j) % num_channels;
                if (!w_gnt_vld && r_pend[idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = cw'(idx);
                end
            end
        end
        if (w_gnt_vld) begin
            w_gnt_onehot[w_gnt_idx] = 1'b1;
        end
    end

    assign w_push = w_gnt_vld;
    assign w_pop  = (r_count != '0) & out_ready;

    // Mode tracker runs through reset so a reset never looks like a mode change
    always_ff @(posedge wb_clk) begin
        r_pack_q <= pack_mode;
    end

    // Packers, pending stage, overflow flags, arbiter pointer and FIFO pointers
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int i = 0; i < num_channels; i++) begin
                r_cnt[i]       <= '0;
                r_part[i]      <= '0;
                r_pend_word[i] <= '0;
            end
            r_pend     <= '0;
            r_ovf      <= '0;
            r_rr_start <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            for (int i = 0; i < num_channels; i++) begin
                if (w_mode_chg || !enable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_acc[i] && pack_mode) begin
                    r_cnt[i] <= w_cmp[i] ? '0 : r_cnt[i] + RW'(1);
                end
                if (w_acc[i] && pack_mode) begin
                    r_part[i] <= w_part_next[i];
                end
                // A grant frees the slot in time for a same-cycle completion.
                if (w_cmp[i] && (!r_pend[i] || w_gnt_onehot[i])) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_word[i] <= w_cmp_word[i];
                end else if (w_gnt_onehot[i]) begin
                    r_pend[i] <= 1'b0;
                end
                r_ovf[i] <= (r_ovf[i] & ~clear_overflow)
                          | (w_cmp[i] & r_pend[i] & ~w_gnt_onehot[i]);
            end
            if (w_gnt_vld) begin
                r_rr_start <= cw'((int'(w_gnt_idx) + 1) % num_channels);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + fifo_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + fifo_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (fifo_aw+1)'(1);
                2'b01:   r_count <= r_count - (fifo_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage, not reset; output is gated to zero while empty
    always_ff @(posedge wb_clk) begin
        if (!wb_rst && w_push) begin
            r_mem_data[r_wr_ptr] <= r_pend_word[w_gnt_idx];
            r_mem_ch[r_wr_ptr]   <= w_gnt_idx;
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_data    = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_channel = out_valid ? r_mem_ch[r_rd_ptr]   : '0;
    assign fifo_count  = r_count;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_wb_daq_multi_channel.sv
module tb_wb_daq_multi_channel;

    localparam int unsigned DW    = 32;
    localparam int unsigned ADW   = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned AW    = 4;
    localparam int unsigned R     = DW / ADW;
    localparam int unsigned DEPTH = 1 << AW;

    logic              wb_clk = 1'b0;
    logic              wb_rst;
    logic [N-1:0]      enable;
    logic              pack_mode;
    logic [N-1:0]      adc_valid;
    logic [N*ADW-1:0]  adc_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_channel;
    logic [AW:0]       fifo_count;
    logic [N-1:0]      overflow;
    logic              clear_overflow;

    int vectors    = 0;
    int miscompares = 0;

    always #5 wb_clk = ~wb_clk;

    wb_daq_multi_channel #(
        .dw(DW), .adc_dw(ADW), .num_channels(N), .cw(CW), .fifo_aw(AW)
    ) dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .enable        (enable),
        .pack_mode     (pack_mode),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_channel   (out_channel),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [ADW-1:0]    m_part [N][$];   // samples collected toward the current word
    logic [N-1:0]      m_pend;
    logic [DW-1:0]     m_pword [N];
    logic [N-1:0]      m_ovf;
    int                m_start;         // first channel searched by the arbiter
    logic              m_prev_mode;
    logic [CW+DW-1:0]  m_fifo [$];      // {channel, word}
    bit                m_live = 1'b0;

    always @(posedge wb_clk) begin : model
        int            g;
        logic [N-1:0]  cmp;
        logic [DW-1:0] nword [N];
        logic [ADW-1:0] s;
        logic [DW-1:0] w;
        if (wb_rst) begin
            for (int c = 0; c < N; c++) m_part[c].delete();
            m_pend  = '0;
            m_ovf   = '0;
            m_start = 0;
            m_fifo.delete();
            m_live  = 1'b1;
        end else if (m_live) begin
            g = -1;
            if (m_fifo.size() < DEPTH)
                for (int j = 0; j < N; j++)
                    if (g < 0 && m_pend[(m_start + j) % N]) g = (m_start + j) % N;
            cmp = '0;
            for (int c = 0; c < N; c++) begin
                s = adc_data[c*ADW +: ADW];
                nword[c] = '0;
                if (pack_mode != m_prev_mode || !enable[c]) begin
                    m_part[c].delete();
                end else if (adc_valid[c]) begin
                    if (!pack_mode) begin
                        cmp[c]   = 1'b1;
                        nword[c] = DW'(s);
                    end else begin
                        m_part[c].push_back(s);
                        if (m_part[c].size() == R) begin
                            w = '0;
                            for (int k = 0; k < R; k++) w = w | (DW'(m_part[c][k]) << (k*ADW));
                            cmp[c]   = 1'b1;
                            nword[c] = w;
                            m_part[c].delete();
                        end
                    end
                end
            end
            if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
            if (g >= 0) begin
                m_fifo.push_back({CW'(g), m_pword[g]});
                m_pend[g] = 1'b0;
                m_start   = (g + 1) % N;
            end
            if (clear_overflow) m_ovf = '0;
            for (int c = 0; c < N; c++) begin
                if (cmp[c]) begin
                    if (m_pend[c]) m_ovf[c] = 1'b1;
                    else begin
                        m_pend[c]  = 1'b1;
                        m_pword[c] = nword[c];
                    end
                end
            end
        end
        m_prev_mode = pack_mode;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge wb_clk) begin
        if (m_live) begin
            chk("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(m_fifo[0][DW-1:0]));
                chk("out_channel", 64'(out_channel), 64'(m_fifo[0][CW+DW-1:DW]));
            end else begin
                chk("out_data_empty", 64'(out_data), 64'd0);
                chk("out_channel_empty", 64'(out_channel), 64'd0);
            end
            chk("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_reset();
        wb_rst    = 1'b1;
        adc_valid = '0;
        tick();
        wb_rst    = 1'b0;
    endtask

    task automatic smp(input int c, input logic [ADW-1:0] v);
        adc_valid    = '0;
        adc_valid[c] = 1'b1;
        adc_data[c*ADW +: ADW] = v;
        tick();
        adc_valid    = '0;
    endtask

    task automatic burst(input string name, input int ord [4]);
        adc_valid = '1;
        for (int c = 0; c < N; c++) adc_data[c*ADW +: ADW] = ADW'(8'h10 + c);
        tick();
        adc_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({name, "_ch"}, 64'(out_channel), 64'(ord[k]));
            chk({name, "_data"}, 64'(out_data), 64'(8'h10 + ord[k]));
        end
        tick();
    endtask

    initial begin
        int got [$];
        int ready_pct;
        int o_a [4];
        int o_b [4];
        wb_rst = 1'b1; enable = '0; pack_mode = 1'b1; adc_valid = '0;
        adc_data = '0; out_ready = 1'b0; clear_overflow = 1'b0;
        tick();
        wb_rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);

        // Packed word on ch0, two-edge latency after the last sample
        enable = 4'b0001;
        smp(0, 8'h11); smp(0, 8'h22); smp(0, 8'h33); smp(0, 8'h44);
        chk("pack_early_valid", 64'(out_valid), 64'd0);
        tick();
        chk("pack_valid", 64'(out_valid), 64'd1);
        chk("pack_data", 64'(out_data), 64'h44332211);
        chk("pack_ch", 64'(out_channel), 64'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pack_pop_count", 64'(fifo_count), 64'd0);

        // Unpacked sample on ch2
        pack_mode = 1'b0; tick();
        enable = 4'b0100;
        smp(2, 8'hA5); tick();
        chk("unpk_data", 64'(out_data), 64'h000000A5);
        chk("unpk_ch", 64'(out_channel), 64'd2);
        tick(); tick();
        chk("unpk_hold_count", 64'(fifo_count), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("unpk_pop_count", 64'(fifo_count), 64'd0);

        // Round-robin ordering of simultaneous completions
        pack_mode = 1'b0; do_reset();
        enable = 4'b1111; out_ready = 1'b1;
        o_a = '{0, 1, 2, 3};
        o_b = '{2, 3, 0, 1};
        burst("rr_first", o_a);
        burst("rr_after3", o_a);
        smp(1, 8'h11); tick(); tick();
        burst("rr_after1", o_b);

        // Fill to full, overflow, clear, drain in order
        out_ready = 1'b0; pack_mode = 1'b0; do_reset();
        enable = 4'b0001;
        for (int k = 1; k <= 18; k++) smp(0, ADW'(k));
        chk("full_count", 64'(fifo_count), 64'd16);
        chk("full_ovf", 64'(overflow), 64'b0001);
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("ovf_clear", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) got.push_back(int'(out_data));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_len", 64'(got.size()), 64'd17);
        for (int k = 0; k < got.size() && k < 17; k++) chk("drain_word", 64'(got[k]), 64'(k + 1));

        // Enable drop and mode toggle discard partial words
        pack_mode = 1'b1; do_reset();
        enable = 4'b0010;
        smp(1, 8'hA1); smp(1, 8'hA2);
        enable = 4'b0000; tick(); enable = 4'b0010;
        smp(1, 8'hB1); smp(1, 8'hB2); smp(1, 8'hB3); smp(1, 8'hB4); tick();
        chk("en_count", 64'(fifo_count), 64'd1);
        chk("en_data", 64'(out_data), 64'hB4B3B2B1);
        tick(); tick();
        chk("en_one_word", 64'(fifo_count), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        smp(1, 8'hC1); smp(1, 8'hC2);
        pack_mode = 1'b0; tick(); pack_mode = 1'b1; tick();
        smp(1, 8'hD1); smp(1, 8'hD2); smp(1, 8'hD3); smp(1, 8'hD4); tick();
        chk("mode_count", 64'(fifo_count), 64'd1);
        chk("mode_data", 64'(out_data), 64'hD4D3D2D1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset mid-operation discards everything
        pack_mode = 1'b0; do_reset();
        enable = 4'b0001;
        for (int k = 1; k <= 6; k++) smp(0, ADW'(k));
        chk("pre_rst_count", 64'(fifo_count), 64'd5);
        do_reset();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_count", 64'(fifo_count), 64'd0);
        end

        // Randomised traffic against the model
        ready_pct = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 500 == 0) ready_pct = (cyc / 500 % 3 == 0) ? 10 : ((cyc / 500 % 3 == 1) ? 90 : 50);
            wb_rst         = ($urandom_range(0, 399) == 0);
            clear_overflow = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) pack_mode = ~pack_mode;
            for (int c = 0; c < N; c++) enable[c] = ($urandom_range(0, 9) != 0);
            adc_valid = N'($urandom);
            adc_data  = (N*ADW)'($urandom);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
        end
        wb_rst = 1'b0; adc_valid = '0; clear_overflow = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
